// File: rtl/ntt_coeff_loader_if.sv
// FIFO read side and coefficient RAM write side of the NTT load stage.
// master is the loader; slave is the FIFO/RAM environment.
interface ntt_coeff_loader_if #(
   parameter int DATA_W = 16,
   parameter int ADDR_W = 8
);
   logic              rd_empty_a;
   logic              rd_empty_b;
   logic [31:0]       rd_data_a;
   logic [31:0]       rd_data_b;
   logic              rd_req;
   logic              we;
   logic [ADDR_W-1:0] address_ina;
   logic [ADDR_W-1:0] address_inb;
   logic [DATA_W-1:0] data_ina;
   logic [DATA_W-1:0] data_inb;

   modport master (
      input  rd_empty_a, rd_empty_b, rd_data_a, rd_data_b,
      output rd_req, we, address_ina, address_inb, data_ina, data_inb
   );

   modport slave (
      output rd_empty_a, rd_empty_b, rd_data_a, rd_data_b,
      input  rd_req, we, address_ina, address_inb, data_ina, data_inb
   );
endinterface

// File: rtl/ntt_coeff_loader.sv
// NTT load stage: drains two 32-bit FIFOs in lockstep and writes one unpacked
// {address, coefficient} pair per cycle into the dual-port coefficient RAM.
module ntt_coeff_loader #(
   parameter int DATA_W = 16,
   parameter int ADDR_W = 8,
   parameter int N_COEF = 256
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   ntt_coeff_loader_if.master bus,
   output logic               busy,
   output logic               in_done,
   output logic               addr_err
);
   localparam int HALF  = N_COEF / 2;
   localparam int CNT_W = $clog2(HALF) + 1;
   localparam logic [CNT_W-1:0] CNT_END = CNT_W'(HALF);

   typedef enum logic [1:0] {IDLE, FETCH, DRAIN, DONE} state_t;

   state_t            state;
   logic [CNT_W-1:0]  issue_cnt;
   logic [CNT_W-1:0]  wr_cnt;
   logic              valid;
   logic [ADDR_W-1:0] addr_a;
   logic [ADDR_W-1:0] addr_b;
   logic              unused_bits;

   assign addr_a      = bus.rd_data_a[16 +: ADDR_W];
   assign addr_b      = bus.rd_data_b[16 +: ADDR_W];
   assign unused_bits = ^{bus.rd_data_a[31:16+ADDR_W], bus.rd_data_b[31:16+ADDR_W]};

   // Shared request only when both FIFOs have data, so A and B never slip.
   assign bus.rd_req = (state == FETCH) && !bus.rd_empty_a && !bus.rd_empty_b
                       && (issue_cnt < CNT_END);
   assign busy       = (state == FETCH) || (state == DRAIN);
   assign in_done    = (state == DONE);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state           <= IDLE;
         issue_cnt       <= '0;
         wr_cnt          <= '0;
         valid           <= 1'b0;
         addr_err        <= 1'b0;
         bus.we          <= 1'b0;
         bus.address_ina <= '0;
         bus.address_inb <= '0;
         bus.data_ina    <= '0;
         bus.data_inb    <= '0;
      end else begin
         valid  <= bus.rd_req;
         bus.we <= valid;
         if (bus.rd_req)
            issue_cnt <= issue_cnt + 1'b1;
         // wr_cnt counts at registration so DONE follows the last we by one cycle.
         if (valid) begin
            bus.address_ina <= addr_a;
            bus.address_inb <= addr_b;
            bus.data_ina    <= bus.rd_data_a[DATA_W-1:0];
            bus.data_inb    <= bus.rd_data_b[DATA_W-1:0];
            wr_cnt          <= wr_cnt + 1'b1;
            if (addr_a == addr_b)
               addr_err <= 1'b1;
         end
         case (state)
            IDLE, DONE: begin
               if (start) begin
                  state     <= FETCH;
                  issue_cnt <= '0;
                  wr_cnt    <= '0;
                  addr_err  <= 1'b0;
               end
            end
            FETCH: if (issue_cnt == CNT_END) state <= DRAIN;
            DRAIN: if (wr_cnt == CNT_END)    state <= DONE;
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_ntt_coeff_loader.sv
// Self-checking bench for ntt_coeff_loader: FIFO model plus a word-level reference
// of the expected RAM writes, timing and sticky address-collision flag.
module tb_ntt_coeff_loader;
   localparam int HALF = 128;

   logic clk;
   logic rst;
   logic start;
   logic busy;
   logic in_done;
   logic addr_err;

   ntt_coeff_loader_if #(.DATA_W(16), .ADDR_W(8)) bus ();

   ntt_coeff_loader #(.DATA_W(16), .ADDR_W(8), .N_COEF(256)) dut (
      .clk      (clk),
      .rst      (rst),
      .start    (start),
      .bus      (bus),
      .busy     (busy),
      .in_done  (in_done),
      .addr_err (addr_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // FIFO model: shared pointers since both FIFOs are read in lockstep.
   logic [31:0] mem_a [0:2047];
   logic [31:0] mem_b [0:2047];
   int          rd_ptr = 0;
   int          wr_ptr = 0;
   int          underflow = 0;
   logic        hold_b = 1'b0;

   assign bus.rd_empty_a = (rd_ptr == wr_ptr);
   assign bus.rd_empty_b = (rd_ptr == wr_ptr) || hold_b;

   always @(posedge clk) begin
      if (bus.rd_req === 1'b1) begin
         if (rd_ptr == wr_ptr || hold_b) underflow <= underflow + 1;
         bus.rd_data_a <= mem_a[rd_ptr];
         bus.rd_data_b <= mem_b[rd_ptr];
         rd_ptr        <= rd_ptr + 1;
      end
   end

   int n_cmp = 0;
   int n_fail = 0;

   // per-load observations
   int   n_rd, n_we, first_rd, last_rd, first_we, last_we, done_cyc, first_err;
   int   gaps, hold_viol, order_bad, err_bad;
   bit   aborted, zero_bad;
   logic busy_c0, done_c0, err_c0;
   logic [15:0] ram_a [0:255];
   logic [15:0] ram_b [0:255];

   task automatic push_pattern(input bit dup7);
      for (int k = 0; k < HALF; k++) begin
         logic [31:0] a, b;
         a = {8'h00, 8'(2 * k), 16'(k)};
         b = {8'h00, 8'(2 * k + 1), ~16'(k)};
         if (dup7 && k == 7) b[23:16] = 8'h0E;
         mem_a[wr_ptr] = a;
         mem_b[wr_ptr] = b;
         wr_ptr++;
      end
   endtask

   task automatic push_random();
      for (int k = 0; k < HALF; k++) begin
         mem_a[wr_ptr] = $urandom;
         mem_b[wr_ptr] = $urandom;
         wr_ptr++;
      end
   endtask

   task automatic run_load(input int hold_at, input int abort_at, input bit poke);
      int          base_ptr, hold_left;
      bit          held, eq_seen;
      logic [31:0] wa, wb;
      base_ptr = rd_ptr;
      n_rd = 0; n_we = 0; first_rd = -1; last_rd = -1; first_we = -1; last_we = -1;
      done_cyc = -1; first_err = -1; gaps = 0; hold_viol = 0; order_bad = 0; err_bad = 0;
      aborted = 0; zero_bad = 0; hold_left = 0; held = 0; eq_seen = 0;
      for (int i = 0; i < 256; i++) begin
         ram_a[i] = 'x;
         ram_b[i] = 'x;
      end
      @(negedge clk) start = 1'b1;
      for (int c = 0; c < 1000; c++) begin
         @(negedge clk);
         start = poke && (c == 20 || (n_rd == HALF && c <= last_rd + 2));
         if (hold_left > 0) hold_left--;
         if (hold_left == 0) hold_b = 1'b0;
         if (hold_at >= 0 && !held && rd_ptr - base_ptr == hold_at) begin
            hold_b = 1'b1; hold_left = 5; held = 1;
         end
         if (abort_at >= 0 && rd_ptr - base_ptr == abort_at) begin
            rst = 1'b0;
            #1;
            zero_bad = (bus.rd_req !== 1'b0) || (bus.we !== 1'b0) || (busy !== 1'b0)
                       || (in_done !== 1'b0) || (addr_err !== 1'b0)
                       || (bus.address_ina !== 8'h00) || (bus.address_inb !== 8'h00)
                       || (bus.data_ina !== 16'h0) || (bus.data_inb !== 16'h0);
            aborted = 1;
            break;
         end
         #1;
         if (bus.rd_req === 1'b1) begin
            if (hold_b) hold_viol++;
            if (last_rd >= 0 && c != last_rd + 1) gaps++;
            if (first_rd < 0) first_rd = c;
            last_rd = c;
            n_rd++;
         end
         if (bus.we === 1'b1 && n_we < 1024) begin
            wa = mem_a[base_ptr + n_we];
            wb = mem_b[base_ptr + n_we];
            if ({bus.address_ina, bus.data_ina, bus.address_inb, bus.data_inb}
                !== {wa[23:16], wa[15:0], wb[23:16], wb[15:0]}) order_bad++;
            ram_a[bus.address_ina] = bus.data_ina;
            ram_b[bus.address_inb] = bus.data_inb;
            if (wa[23:16] == wb[23:16]) eq_seen = 1;
            if (first_we < 0) first_we = c;
            last_we = c;
            n_we++;
         end
         if (addr_err !== eq_seen) err_bad++;
         if (addr_err === 1'b1 && first_err < 0) first_err = c;
         if (c == 0) begin
            busy_c0 = busy; done_c0 = in_done; err_c0 = addr_err;
         end
         if (in_done === 1'b1) begin
            done_cyc = c;
            break;
         end
      end
      start  = 1'b0;
      hold_b = 1'b0;
   endtask

   task automatic test_reset();
      int p;
      rst = 1'b0; start = 1'b0;
      repeat (2) @(negedge clk);
      n_cmp++; if ({bus.rd_req, bus.we, busy, in_done, addr_err} !== 5'b0) begin
         n_fail++; $display("FAIL reset_flags: got %b want 00000", {bus.rd_req, bus.we, busy, in_done, addr_err}); end
      n_cmp++; if ({bus.address_ina, bus.address_inb, bus.data_ina, bus.data_inb} !== 48'h0) begin
         n_fail++; $display("FAIL reset_bus: got %h want 0", {bus.address_ina, bus.address_inb, bus.data_ina, bus.data_inb}); end
      rst = 1'b1;
      push_pattern(1'b0);
      p = rd_ptr;
      repeat (4) @(negedge clk);
      n_cmp++; if (rd_ptr !== p || bus.rd_req !== 1'b0) begin
         n_fail++; $display("FAIL idle_no_read: got %0d reads want 0", rd_ptr - p); end
   endtask

   task automatic test_basic_load();
      run_load(-1, -1, 1'b0);
      n_cmp++; if (busy_c0 !== 1'b1) begin n_fail++; $display("FAIL basic_busy: got %b want 1", busy_c0); end
      n_cmp++; if (first_rd !== 0) begin n_fail++; $display("FAIL basic_first_rd: got %0d want 0", first_rd); end
      n_cmp++; if (n_rd !== HALF || gaps !== 0) begin
         n_fail++; $display("FAIL basic_rd_burst: got %0d reads %0d gaps want 128/0", n_rd, gaps); end
      n_cmp++; if (first_we !== first_rd + 2) begin
         n_fail++; $display("FAIL basic_first_we: got %0d want %0d", first_we, first_rd + 2); end
      n_cmp++; if (n_we !== HALF || last_we !== last_rd + 2) begin
         n_fail++; $display("FAIL basic_we: got %0d pulses last %0d want 128 last %0d", n_we, last_we, last_rd + 2); end
      n_cmp++; if (done_cyc !== last_rd + 3) begin
         n_fail++; $display("FAIL basic_done_lat: got %0d want %0d", done_cyc, last_rd + 3); end
      n_cmp++; if (addr_err !== 1'b0 || err_bad !== 0) begin
         n_fail++; $display("FAIL basic_addr_err: got %b (%0d bad cycles) want 0", addr_err, err_bad); end
      begin
         int bad;
         bad = 0;
         for (int k = 0; k < HALF; k++) begin
            if (ram_a[2 * k] !== 16'(k)) bad++;
            if (ram_b[2 * k + 1] !== ~16'(k)) bad++;
         end
         n_cmp++; if (bad !== 0) begin n_fail++; $display("FAIL basic_ram_image: got %0d bad entries want 0", bad); end
      end
      n_cmp++; if (busy !== 1'b0 || underflow !== 0) begin
         n_fail++; $display("FAIL basic_end_state: got busy %b underflow %0d want 0/0", busy, underflow); end
   endtask

   task automatic test_fifo_stall();
      push_random();
      run_load(10, -1, 1'b0);
      n_cmp++; if (hold_viol !== 0 || underflow !== 0) begin
         n_fail++; $display("FAIL stall_rd_while_empty: got %0d/%0d want 0/0", hold_viol, underflow); end
      n_cmp++; if (gaps !== 1 || last_rd !== HALF - 1 + 5) begin
         n_fail++; $display("FAIL stall_gap: got %0d gaps last %0d want 1 last %0d", gaps, last_rd, HALF + 4); end
      n_cmp++; if (n_we !== HALF || order_bad !== 0) begin
         n_fail++; $display("FAIL stall_pairs: got %0d writes %0d misordered want 128/0", n_we, order_bad); end
      n_cmp++; if (done_cyc !== last_rd + 3 || err_bad !== 0) begin
         n_fail++; $display("FAIL stall_done: got %0d (err_bad %0d) want %0d", done_cyc, err_bad, last_rd + 3); end
   endtask

   task automatic test_addr_err();
      push_pattern(1'b1);
      run_load(-1, -1, 1'b0);
      n_cmp++; if (first_err !== first_we + 7) begin
         n_fail++; $display("FAIL err_first: got %0d want %0d", first_err, first_we + 7); end
      n_cmp++; if (err_bad !== 0 || addr_err !== 1'b1) begin
         n_fail++; $display("FAIL err_sticky: got %b (%0d bad cycles) want 1", addr_err, err_bad); end
      n_cmp++; if (n_we !== HALF || order_bad !== 0) begin
         n_fail++; $display("FAIL err_completes: got %0d writes %0d misordered want 128/0", n_we, order_bad); end
      push_pattern(1'b0);
      run_load(-1, -1, 1'b0);
      n_cmp++; if (err_c0 !== 1'b0 || addr_err !== 1'b0) begin
         n_fail++; $display("FAIL err_cleared: got %b/%b want 0/0", err_c0, addr_err); end
   endtask

   task automatic test_reset_midload();
      push_random();
      run_load(-1, 40, 1'b0);
      n_cmp++; if (aborted !== 1'b1 || zero_bad !== 1'b0) begin
         n_fail++; $display("FAIL abort_outputs: got aborted %b zero_bad %b want 1/0", aborted, zero_bad); end
      n_cmp++; if (wr_ptr - rd_ptr !== 88) begin
         n_fail++; $display("FAIL abort_remaining: got %0d want 88", wr_ptr - rd_ptr); end
      n_cmp++; if (n_we !== 38 || order_bad !== 0) begin
         n_fail++; $display("FAIL abort_writes: got %0d (%0d misordered) want 38/0", n_we, order_bad); end
      repeat (2) @(negedge clk);
      rst = 1'b1;
      repeat (3) @(negedge clk);
      n_cmp++; if (wr_ptr - rd_ptr !== 88 || busy !== 1'b0) begin
         n_fail++; $display("FAIL abort_idle: got %0d left busy %b want 88/0", wr_ptr - rd_ptr, busy); end
      wr_ptr = rd_ptr;
      push_random();
      run_load(-1, -1, 1'b0);
      n_cmp++; if (n_we !== HALF || order_bad !== 0 || err_bad !== 0) begin
         n_fail++; $display("FAIL reload: got %0d writes %0d/%0d bad want 128/0/0", n_we, order_bad, err_bad); end
      n_cmp++; if (done_cyc !== last_rd + 3 || wr_ptr !== rd_ptr) begin
         n_fail++; $display("FAIL reload_done: got %0d left %0d want %0d/0", done_cyc, wr_ptr - rd_ptr, last_rd + 3); end
   endtask

   task automatic test_start_ignored();
      push_random();
      run_load(-1, -1, 1'b1);
      n_cmp++; if (n_rd !== HALF || gaps !== 0 || last_rd !== HALF - 1) begin
         n_fail++; $display("FAIL poke_reads: got %0d reads last %0d want 128 last 127", n_rd, last_rd); end
      n_cmp++; if (n_we !== HALF || order_bad !== 0 || err_bad !== 0) begin
         n_fail++; $display("FAIL poke_writes: got %0d writes %0d/%0d bad want 128/0/0", n_we, order_bad, err_bad); end
      n_cmp++; if (done_cyc !== HALF + 2) begin
         n_fail++; $display("FAIL poke_done: got %0d want %0d", done_cyc, HALF + 2); end
      push_random();
      run_load(-1, -1, 1'b0);
      n_cmp++; if (done_c0 !== 1'b0 || busy_c0 !== 1'b1) begin
         n_fail++; $display("FAIL restart_from_done: got in_done %b busy %b want 0/1", done_c0, busy_c0); end
      n_cmp++; if (n_we !== HALF || order_bad !== 0 || done_cyc !== last_rd + 3) begin
         n_fail++; $display("FAIL restart_load: got %0d writes done %0d want 128 done %0d", n_we, done_cyc, last_rd + 3); end
   endtask

   initial begin
      test_reset();
      test_basic_load();
      test_fifo_stall();
      test_addr_err();
      test_reset_midload();
      test_start_ignored();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule
